// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// Opcode constants, ALU/immediate/writeback/next-PC encodings, FSM states
// and the decoded control bundle carried from DECODE to later states.
package cu_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SLT   = 4'd7,
        ALU_SLTU  = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_NONE  = 4'd15
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    // Writeback source
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Next-PC source
    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_JAL  = 2'b01;
    localparam logic [1:0] NPC_BR   = 2'b10;
    localparam logic [1:0] NPC_JALR = 2'b11;

    // Operand selects
    localparam logic [1:0] OPA_RS1  = 2'b00;
    localparam logic [1:0] OPA_PC   = 2'b01;
    localparam logic [1:0] OPA_ZERO = 2'b10;
    localparam logic       OPB_RS2  = 1'b0;
    localparam logic       OPB_IMM  = 1'b1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef struct packed {
        alu_op_e    alu;
        imm_sel_e   imm;
        logic [1:0] op_a;
        logic       op_b;
        logic [1:0] wb_sel;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       reg_wr;
        logic       illegal;
    } ctrl_t;

    // ALU op for R-type and I-type ALU instructions; SUB exists only in R-type
    function automatic alu_op_e alu_from_fun3(input logic [2:0] f3, input logic f7,
                                              input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: opcode/fun3/func7 -> control bundle.
// Unknown opcodes produce an all-quiet bundle with the illegal flag set.
module cu_decoder
    import cu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] fun3,
    input  logic       func7,
    output ctrl_t      ctrl
);

    // Decode one instruction; defaults describe a harmless no-op
    always_comb begin
        ctrl        = '0;
        ctrl.alu    = ALU_NONE;
        ctrl.imm    = IMM_I;
        ctrl.op_a   = OPA_RS1;
        ctrl.op_b   = OPB_IMM;
        ctrl.wb_sel = WB_ALU;
        case (opcode)
            OPC_R: begin
                ctrl.alu    = alu_from_fun3(fun3, func7, 1'b1);
                ctrl.op_b   = OPB_RS2;
                ctrl.reg_wr = 1'b1;
            end
            OPC_I: begin
                ctrl.alu    = alu_from_fun3(fun3, func7, 1'b0);
                ctrl.reg_wr = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.alu     = ALU_ADD;
                ctrl.wb_sel  = WB_MEM;
                ctrl.is_load = 1'b1;
                ctrl.reg_wr  = 1'b1;
            end
            OPC_STORE: begin
                ctrl.alu      = ALU_ADD;
                ctrl.imm      = IMM_S;
                ctrl.is_store = 1'b1;
            end
            OPC_BRANCH: begin
                // ALU forms the branch target; the comparator is external
                ctrl.alu       = ALU_ADD;
                ctrl.imm       = IMM_B;
                ctrl.op_a      = OPA_PC;
                ctrl.is_branch = 1'b1;
            end
            OPC_LUI: begin
                ctrl.alu    = ALU_PASSB;
                ctrl.imm    = IMM_U;
                ctrl.op_a   = OPA_ZERO;
                ctrl.reg_wr = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.alu    = ALU_ADD;
                ctrl.imm    = IMM_U;
                ctrl.op_a   = OPA_PC;
                ctrl.reg_wr = 1'b1;
            end
            OPC_JAL: begin
                ctrl.alu    = ALU_NONE;
                ctrl.imm    = IMM_J;
                ctrl.op_a   = OPA_PC;
                ctrl.wb_sel = WB_PC4;
                ctrl.is_jal = 1'b1;
                ctrl.reg_wr = 1'b1;
            end
            OPC_JALR: begin
                ctrl.alu     = ALU_ADD;
                ctrl.wb_sel  = WB_PC4;
                ctrl.is_jalr = 1'b1;
                ctrl.reg_wr  = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB FSM with a memory wait
// timeout (ERR) and registered decoded controls.
// Optional: define MC_CU_TRAP_EN to send illegal opcodes to a sticky TRAP
// state; otherwise they run as a NOP that only advances the PC.
module mc_control_unit
    import cu_pkg::*;
#(
    parameter int ALU_CW   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        opcode,
    input  logic [2:0]        fun3,
    input  logic              func7,
    input  logic              mem_ready,
    input  logic              branch_taken,
    output logic [ALU_CW-1:0] ALU_C,
    output logic [1:0]        N_PC,
    output logic [2:0]        IMM_sel,
    output logic [1:0]        OP_A,
    output logic              OP_B,
    output logic [1:0]        wb_sel,
    output logic              ir_we,
    output logic              pc_we,
    output logic              reg_write,
    output logic              mem_req,
    output logic              mem_we,
    output logic              bus_err,
    output logic              illegal,
    output logic [2:0]        state_o
);

    // Last count value before the timeout fires; a ready in that cycle still wins
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt;
    ctrl_t      dec, ctrl_q;
    logic       timeout;

    cu_decoder u_dec (
        .opcode (opcode),
        .fun3   (fun3),
        .func7  (func7),
        .ctrl   (dec)
    );

    assign timeout = (wait_cnt == WAIT_LAST) && !mem_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Wait counter: cleared on any state change, counts stalled memory cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state_d != state_q)
            wait_cnt <= '0;
        else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready)
            wait_cnt <= wait_cnt + 8'd1;
    end

    // Decoded controls captured in DECODE and held until the next DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 ctrl_q <= '0;
        else if (state_q == S_DECODE) ctrl_q <= dec;
    end

    assign ALU_C   = ALU_CW'(ctrl_q.alu);
    assign IMM_sel = ctrl_q.imm;
    assign OP_A    = ctrl_q.op_a;
    assign OP_B    = ctrl_q.op_b;
    assign wb_sel  = ctrl_q.wb_sel;
    assign state_o = state_q;

    // Next-state and per-state strobes; all strobes forced low while in reset
    always_comb begin
        state_d   = state_q;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_write = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        bus_err   = 1'b0;
        illegal   = 1'b0;
        N_PC      = NPC_PC4;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
`ifdef MC_CU_TRAP_EN
                state_d = dec.illegal ? S_TRAP : S_EXEC;
`else
                state_d = S_EXEC;
`endif
            end
            S_EXEC: begin
                if (ctrl_q.is_load || ctrl_q.is_store) begin
                    state_d = S_MEM;
                end else if (ctrl_q.is_branch) begin
                    pc_we   = 1'b1;
                    N_PC    = branch_taken ? NPC_BR : NPC_PC4;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = ctrl_q.is_store;
                if (mem_ready) begin
                    if (ctrl_q.is_store) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                // Illegal NOPs arrive here with reg_wr clear: PC advances only
                reg_write = ctrl_q.reg_wr & ~ctrl_q.illegal;
                pc_we     = 1'b1;
                if (ctrl_q.is_jal)       N_PC = NPC_JAL;
                else if (ctrl_q.is_jalr) N_PC = NPC_JALR;
                state_d = S_FETCH;
            end
            S_ERR:  bus_err = 1'b1;
            S_TRAP: illegal = 1'b1;
            default: state_d = S_FETCH;
        endcase
        if (!rst_n) begin
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            reg_write = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            bus_err   = 1'b0;
            illegal   = 1'b0;
            N_PC      = NPC_PC4;
        end
    end

endmodule
